// File: rtl/r16_wd_align_fifo_pkg.sv
// ----------------------------------------------------------------------------
// r16_wd_align_fifo_pkg
//   Constants shared by the radix-16 twiddle alignment buffer, the DTFAG top
//   and the bench: per-lane twiddle width, lanes per beat, buffer depth and
//   the derived occupancy-counter / pointer widths.
// ----------------------------------------------------------------------------
package r16_wd_align_fifo_pkg;

    localparam int R16_D_WIDTH = 64;                  // per-lane twiddle width
    localparam int R16_LANES   = 16;                  // radix-16: fixed
    localparam int R16_DEPTH   = 32;                  // >= 21-cycle generator pipe + 1
    localparam int R16_CNT_W   = $clog2(R16_DEPTH) + 1;
    localparam int R16_PTR_W   = $clog2(R16_DEPTH);
    localparam int R16_BEAT_W  = R16_LANES * R16_D_WIDTH;

    typedef logic [R16_D_WIDTH-1:0] r16_lane_t;

endpackage

// File: rtl/r16_wd_align_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// r16_wd_fifo_ctrl
//   Control half of the twiddle alignment FIFO: read/write pointers, the
//   occupancy counter, full/empty flags, sticky overflow and (optionally) the
//   high-water mark. Holds no beat data.
//
//   Optional feature: define R16_WD_ALIGN_HWM_EN to add the hwm_o output.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid_i     producer presents a beat
//   out_ready_i    consumer takes the head beat
//   in_ready_o     room for a beat (not full); registered-state only
//   out_valid_o    head beat available (not empty)
//   wr_en_o        storage write strobe (accepted push)
//   wr_addr_o      storage write index
//   rd_addr_o      storage read index (head)
//   level_o        occupancy 0..DEPTH
//   overflow_o     sticky: push attempted while full
//   hwm_o          high-water mark of level (R16_WD_ALIGN_HWM_EN only)
// ----------------------------------------------------------------------------
module r16_wd_fifo_ctrl
    import r16_wd_align_fifo_pkg::*;
#(
    parameter int DEPTH = R16_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [PTR_W-1:0] rd_addr_o,
    output logic [CNT_W-1:0] level_o,
`ifdef R16_WD_ALIGN_HWM_EN
    output logic             overflow_o,
    output logic [CNT_W-1:0] hwm_o
`else
    output logic             overflow_o
`endif
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push, pop;

    // Flags come only from registered level, so a same-cycle pop never
    // re-opens in_ready and out_ready never reaches in_ready.
    assign full  = (level_q == CNT_W'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = in_valid_i & ~full;
    assign pop   = out_ready_i & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (in_valid_i & full);
        // DEPTH is a power of 2, so pointer overflow is the modulo wrap.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef R16_WD_ALIGN_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    // Tracks next-state level so the mark is current the cycle it is reached.
    assign hwm_d = (level_d > hwm_q) ? level_d : hwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`endif

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign wr_en_o     = push;
    assign wr_addr_o   = wr_ptr_q;
    assign rd_addr_o   = rd_ptr_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/r16_wd_align_fifo.sv
// ----------------------------------------------------------------------------
// r16_wd_align_fifo
//   Receive-side twiddle alignment buffer for the radix-16 DTFAG datapath.
//   The generator pushes 16-lane twiddle beats; the butterfly stage pops them
//   with valid/ready when its operands are ready. Strict FIFO order, lanes
//   stay together, first-word-fall-through with 1-cycle push-to-out latency
//   (no empty bypass). wd_out is forced to zero whenever no beat is valid.
//
//   Optional feature: define R16_WD_ALIGN_HWM_EN to add the hwm port.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   wd_in_valid    generator presents a beat
//   wd_in_ready    buffer can accept a beat (not full)
//   wd_in          beat, lane k = [k*D_WIDTH +: D_WIDTH]
//   wd_out_valid   head beat available
//   wd_out_ready   butterfly consumes the head beat
//   wd_out         head beat, all-zero when wd_out_valid=0
//   level          occupancy 0..DEPTH
//   overflow       sticky: push attempted while full
//   hwm            high-water mark of level (R16_WD_ALIGN_HWM_EN only)
// ----------------------------------------------------------------------------
module r16_wd_align_fifo
    import r16_wd_align_fifo_pkg::*;
#(
    parameter int D_WIDTH = R16_D_WIDTH,
    parameter int LANES   = R16_LANES,
    parameter int DEPTH   = R16_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wd_in_valid,
    output logic                     wd_in_ready,
    input  logic [LANES*D_WIDTH-1:0] wd_in,
    output logic                     wd_out_valid,
    input  logic                     wd_out_ready,
    output logic [LANES*D_WIDTH-1:0] wd_out,
    output logic [CNT_W-1:0]         level,
`ifdef R16_WD_ALIGN_HWM_EN
    output logic                     overflow,
    output logic [CNT_W-1:0]         hwm
`else
    output logic                     overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr, rd_addr;

    r16_wd_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (wd_in_valid),
        .out_ready_i (wd_out_ready),
        .in_ready_o  (wd_in_ready),
        .out_valid_o (wd_out_valid),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .rd_addr_o   (rd_addr),
        .level_o     (level),
`ifdef R16_WD_ALIGN_HWM_EN
        .overflow_o  (overflow),
        .hwm_o       (hwm)
`else
        .overflow_o  (overflow)
`endif
    );

    // Beat storage is deliberately not reset; the zero-mask on wd_out keeps
    // the output X-free until a beat has been written.
    logic [LANES*D_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wd_in;
    end

    assign wd_out = wd_out_valid ? mem_q[rd_addr] : '0;

endmodule

// File: tb/tb_r16_wd_align_fifo.sv
module tb_r16_wd_align_fifo;
    import r16_wd_align_fifo_pkg::*;

    localparam int W = R16_BEAT_W;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wd_in_valid = 1'b0;
    logic                 wd_in_ready;
    logic [W-1:0]         wd_in = '0;
    logic                 wd_out_valid;
    logic                 wd_out_ready = 1'b0;
    logic [W-1:0]         wd_out;
    logic [R16_CNT_W-1:0] level;
    logic                 overflow;
`ifdef R16_WD_ALIGN_HWM_EN
    logic [R16_CNT_W-1:0] hwm;
`endif

    int checks   = 0;
    int failures = 0;

    r16_wd_align_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wd_in_valid  (wd_in_valid),
        .wd_in_ready  (wd_in_ready),
        .wd_in        (wd_in),
        .wd_out_valid (wd_out_valid),
        .wd_out_ready (wd_out_ready),
        .wd_out       (wd_out),
        .level        (level),
`ifdef R16_WD_ALIGN_HWM_EN
        .overflow     (overflow),
        .hwm          (hwm)
`else
        .overflow     (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // lane0 = beat index; other lanes tagged with lane number and index
    function automatic logic [W-1:0] beat(int i);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < R16_LANES; k++)
            if (k == 0) b[0 +: 64] = 64'(i);
            else        b[k*64 +: 64] = {16'hA5A5, 16'(k), 32'(i)};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        logic [15:0] diff;
        diff = '0;
        for (int k = 0; k < R16_LANES; k++)
            diff[k] = (obs[k*64 +: 64] !== exp[k*64 +: 64]);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lane0 observed=%0h expected=%0h lane_diff_mask=%04h",
                   tag, obs[63:0], exp[63:0], diff);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wd_in_valid  = 1'b0;
        wd_out_ready = 1'b0;
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wd_in       = beat(base + i);
            wd_in_valid = 1'b1;
            tick();
        end
        wd_in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        wd_out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        wd_out_ready = 1'b0;
    endtask

    logic [W-1:0] b1;
    int q[$];
    int pushed, popped, cyc;
    bit v, r, do_push, do_pop;

    initial begin
        // ---- reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(wd_in_ready), 64'd1);
        chk("rst_out_valid", 64'(wd_out_valid), 64'd0);
        chk_beat("rst_wd_out", wd_out, '0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        #1;

        // ---- 1: single beat, 1-cycle latency, pop clears
        for (int k = 0; k < R16_LANES; k++) b1[k*64 +: 64] = 64'h1000 + 64'(k);
        wd_in = b1;
        wd_in_valid = 1'b1;
        #1;
        chk("t1_no_bypass", 64'(wd_out_valid), 64'd0);
        tick();
        wd_in_valid = 1'b0;
        chk("t1_valid", 64'(wd_out_valid), 64'd1);
        chk_beat("t1_data", wd_out, b1);
        chk("t1_level", 64'(level), 64'd1);
        pop_n(1);
        chk("t1_pop_valid", 64'(wd_out_valid), 64'd0);
        chk_beat("t1_pop_zero", wd_out, '0);
        chk("t1_pop_level", 64'(level), 64'd0);

        // push & pop at level 1: new beat becomes head
        push_n(200, 1);
        wd_in = beat(201);
        wd_in_valid = 1'b1;
        wd_out_ready = 1'b1;
        tick();
        wd_in_valid = 1'b0;
        wd_out_ready = 1'b0;
        chk_beat("t1_pp_head", wd_out, beat(201));
        chk("t1_pp_level", 64'(level), 64'd1);

        // ---- 2: fill, overflow, drain in order
        do_reset();
        push_n(0, 32);
        chk("t2_level_full", 64'(level), 64'd32);
        chk("t2_in_ready_full", 64'(wd_in_ready), 64'd0);
        chk("t2_no_ovf_yet", 64'(overflow), 64'd0);
        push_n(99, 1);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_level_after_ovf", 64'(level), 64'd32);
        wd_out_ready = 1'b1;
        #1;
        chk("t2_pop_no_reopen", 64'(wd_in_ready), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk_beat("t2_drain", wd_out, beat(i));
            tick();
        end
        wd_out_ready = 1'b0;
        chk("t2_level_empty", 64'(level), 64'd0);
        chk("t2_ovf_sticky", 64'(overflow), 64'd1);

        // ---- 3: steady push&pop at level 5 across pointer wrap
        do_reset();
        push_n(0, 5);
        wd_in_valid = 1'b1;
        wd_out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            wd_in = beat(5 + c);
            #1;
            chk_beat("t3_order", wd_out, beat(c));
            tick();
            chk("t3_level", 64'(level), 64'd5);
        end
        wd_in_valid = 1'b0;
        wd_out_ready = 1'b0;

        // ---- 4: random valid/ready against a scoreboard
        do_reset();
        q.delete();
        pushed = 0;
        popped = 0;
        cyc = 0;
        while (popped < 2000 && cyc < 20000) begin
            v = ($urandom_range(99) < 50) && (pushed < 2000) && (q.size() < 32);
            r = ($urandom_range(99) < 30);
            wd_in = beat(pushed);
            wd_in_valid = v;
            wd_out_ready = r;
            #1;
            chk("t4_out_valid", 64'(wd_out_valid), 64'(q.size() != 0));
            chk("t4_in_ready", 64'(wd_in_ready), 64'(q.size() < 32));
            do_pop = r && (q.size() != 0);
            do_push = v;
            if (do_pop) chk_beat("t4_data", wd_out, beat(q[0]));
            else if (q.size() == 0) chk_beat("t4_empty_zero", wd_out, '0);
            tick();
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) begin
                q.push_back(pushed);
                pushed++;
            end
            chk("t4_level", 64'(level), 64'(q.size()));
            cyc++;
        end
        wd_in_valid = 1'b0;
        wd_out_ready = 1'b0;
        chk("t4_all_popped", 64'(popped), 64'd2000);
        chk("t4_no_overflow", 64'(overflow), 64'd0);

        // ---- 5: async reset mid-stream at level 17
        do_reset();
        push_n(300, 33);  // 32 accepted, last one sets overflow
        pop_n(15);
        chk("t5_level17", 64'(level), 64'd17);
        chk("t5_ovf_before", 64'(overflow), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_level", 64'(level), 64'd0);
        chk("t5_rst_valid", 64'(wd_out_valid), 64'd0);
        chk_beat("t5_rst_out", wd_out, '0);
        chk("t5_rst_ovf", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        push_n(500, 2);
        chk_beat("t5_first_after_rst", wd_out, beat(500));
        pop_n(1);
        chk_beat("t5_second_after_rst", wd_out, beat(501));

`ifdef R16_WD_ALIGN_HWM_EN
        // ---- 6: high-water mark
        do_reset();
        chk("t6_hwm_rst", 64'(hwm), 64'd0);
        push_n(0, 23);
        chk("t6_hwm_fill", 64'(hwm), 64'd23);
        pop_n(23);
        chk("t6_level_drained", 64'(level), 64'd0);
        chk("t6_hwm_drain", 64'(hwm), 64'd23);
        push_n(0, 10);
        chk("t6_level_refill", 64'(level), 64'd10);
        chk("t6_hwm_refill", 64'(hwm), 64'd23);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
